red_fetch_decode: RTL and testbench

- Front end of the reduced RISC-V pipeline. Holds the PC and addresses instruction memory.
- Latches each fetched word into an IF/ID register, then decodes it into the control and operand fields the execute datapath consumes (ImmOp, rs1/rs2/rd, RegWrite, ALUctrl, ALUsrc, MemWrite, ResultSrc).
- Decoded fields are registered in an ID/EX stage.
- Resolves BNE using the execute stage's Zero flag, redirecting the PC and flushing younger instructions.

---
 rtl/red_fetch_decode.sv | 170 +++++++++++++++++
 tb/tb_red_fetch_decode.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/red_fetch_decode.sv
// Fetch/decode front end: PC register, IF/ID latch, decoder and ID/EX register.
// BNE is resolved when it sits in ID/EX, using the execute stage's Zero flag.
module red_fetch_decode #(
    parameter int                    ADDRESS_WIDTH = 5,
    parameter int                    ALUctrl_WIDTH = 3,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    instr,
    input  logic                     stall,
    input  logic                     Zero,
    output logic [DATA_WIDTH-1:0]    pc,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     RegWrite,
    output logic [ALUctrl_WIDTH-1:0] ALUctrl,
    output logic                     ALUsrc,
    output logic                     MemWrite,
    output logic                     ResultSrc,
    output logic                     valid,
    output logic                     illegal
);

    typedef struct packed {
        logic                     valid;
        logic                     illegal;
        logic [DATA_WIDTH-1:0]    imm;
        logic [ADDRESS_WIDTH-1:0] rs1;
        logic [ADDRESS_WIDTH-1:0] rs2;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic                     regwrite;
        logic [ALUctrl_WIDTH-1:0] aluctrl;
        logic                     alusrc;
        logic                     memwrite;
        logic                     resultsrc;
        logic                     is_bne;
        logic [DATA_WIDTH-1:0]    br_target;
    } idex_t;

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [DATA_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic                  ifid_valid_q, ifid_valid_d;
    idex_t                 idex_q, idex_d;
    idex_t                 dec;
    logic                  dec_legal;
    logic                  taken;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b;

    assign opcode = ifid_instr_q[6:0];
    assign funct3 = ifid_instr_q[14:12];
    assign funct7 = ifid_instr_q[31:25];
    assign imm_i  = {{(DATA_WIDTH-12){ifid_instr_q[31]}}, ifid_instr_q[31:20]};
    assign imm_s  = {{(DATA_WIDTH-12){ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
    assign imm_b  = {{(DATA_WIDTH-13){ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                     ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};

    // Decode of the IF/ID word; fields not used by an instruction stay 0.
    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        case (opcode)
            7'b0010011: if (funct3 == 3'b000) begin
                dec_legal    = 1'b1;
                dec.imm      = imm_i;
                dec.rs1      = ADDRESS_WIDTH'(ifid_instr_q[19:15]);
                dec.rd       = ADDRESS_WIDTH'(ifid_instr_q[11:7]);
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            7'b0110011: if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                dec_legal    = 1'b1;
                dec.rs1      = ADDRESS_WIDTH'(ifid_instr_q[19:15]);
                dec.rs2      = ADDRESS_WIDTH'(ifid_instr_q[24:20]);
                dec.rd       = ADDRESS_WIDTH'(ifid_instr_q[11:7]);
                dec.regwrite = 1'b1;
            end
            7'b0000011: if (funct3 == 3'b010) begin
                dec_legal     = 1'b1;
                dec.imm       = imm_i;
                dec.rs1       = ADDRESS_WIDTH'(ifid_instr_q[19:15]);
                dec.rd        = ADDRESS_WIDTH'(ifid_instr_q[11:7]);
                dec.alusrc    = 1'b1;
                dec.regwrite  = 1'b1;
                dec.resultsrc = 1'b1;
            end
            7'b0100011: if (funct3 == 3'b010) begin
                dec_legal    = 1'b1;
                dec.imm      = imm_s;
                dec.rs1      = ADDRESS_WIDTH'(ifid_instr_q[19:15]);
                dec.rs2      = ADDRESS_WIDTH'(ifid_instr_q[24:20]);
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            7'b1100011: if (funct3 == 3'b001) begin
                dec_legal     = 1'b1;
                dec.imm       = imm_b;
                dec.rs1       = ADDRESS_WIDTH'(ifid_instr_q[19:15]);
                dec.rs2       = ADDRESS_WIDTH'(ifid_instr_q[24:20]);
                dec.aluctrl   = ALUctrl_WIDTH'(3'b001);
                dec.is_bne    = 1'b1;
                dec.br_target = ifid_pc_q + imm_b;
            end
            default: ;
        endcase
        dec.valid = dec_legal;
    end

    assign taken = idex_q.valid & idex_q.is_bne & ~Zero;

    // A taken branch outranks stall: redirect and flush both younger stages.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        idex_d       = '0;
        if (taken) begin
            pc_d         = idex_q.br_target;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d         = pc_q + DATA_WIDTH'(4);
            ifid_instr_d = instr;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
            if (ifid_valid_q) begin
                if (dec_legal) idex_d = dec;
                else           idex_d.illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= PC_RESET;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            idex_q       <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            idex_q       <= idex_d;
        end
    end

    assign pc        = pc_q;
    assign ImmOp     = idex_q.imm;
    assign rs1       = idex_q.rs1;
    assign rs2       = idex_q.rs2;
    assign rd        = idex_q.rd;
    assign RegWrite  = idex_q.regwrite;
    assign ALUctrl   = idex_q.aluctrl;
    assign ALUsrc    = idex_q.alusrc;
    assign MemWrite  = idex_q.memwrite;
    assign ResultSrc = idex_q.resultsrc;
    assign valid     = idex_q.valid;
    assign illegal   = idex_q.illegal;

endmodule

// File: tb/tb_red_fetch_decode.sv
// Bench for red_fetch_decode: a ROM drives instr from pc; per-cycle expected
// {pc, outputs} records are queued by the driver and checked by a monitor.
module tb_red_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        stall;
    logic        Zero;
    logic [31:0] pc;
    logic [31:0] ImmOp;
    logic [4:0]  rs1, rs2, rd;
    logic        RegWrite;
    logic [2:0]  ALUctrl;
    logic        ALUsrc, MemWrite, ResultSrc, valid, illegal;

    red_fetch_decode dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .stall(stall), .Zero(Zero),
        .pc(pc), .ImmOp(ImmOp), .rs1(rs1), .rs2(rs2), .rd(rd),
        .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
        .MemWrite(MemWrite), .ResultSrc(ResultSrc), .valid(valid), .illegal(illegal)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rom [0:63];
    assign instr = rom[pc[7:2]];

    // Output record: {valid, illegal, imm, rs1, rs2, rd, RegWrite, ALUctrl, ALUsrc, MemWrite, ResultSrc}
    localparam logic [55:0] BUB   = 56'h0;
    localparam logic [55:0] ILL   = {1'b0, 1'b1, 54'h0};
    localparam logic [55:0] ADDI1 = {1'b1, 1'b0, 32'h0000_0005, 5'd0, 5'd0, 5'd1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0};
    localparam logic [55:0] SW    = {1'b1, 1'b0, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0};
    localparam logic [55:0] ADD3  = {1'b1, 1'b0, 32'h0000_0000, 5'd1, 5'd2, 5'd3, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    localparam logic [55:0] LW4   = {1'b1, 1'b0, 32'h0000_0008, 5'd2, 5'd0, 5'd4, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1};
    localparam logic [55:0] BNE   = {1'b1, 1'b0, 32'hFFFF_FFF8, 5'd1, 5'd2, 5'd0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0};
    localparam logic [55:0] ADDI5 = {1'b1, 1'b0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd5, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0};
    localparam logic [55:0] ADDI6 = {1'b1, 1'b0, 32'h0000_0006, 5'd0, 5'd0, 5'd6, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0};
    localparam logic [55:0] ADDI7 = {1'b1, 1'b0, 32'h0000_0007, 5'd0, 5'd0, 5'd7, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0};
    localparam logic [55:0] NOP   = {1'b1, 1'b0, 32'h0000_0000, 5'd0, 5'd0, 5'd0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0};

    // rs2 is unused by I-type, ImmOp unused by add
    localparam logic [55:0] M_ALL = {56{1'b1}};
    localparam logic [55:0] M_I   = ~(56'h1F << 12);
    localparam logic [55:0] M_R   = ~(56'hFFFF_FFFF << 22);

    // scoreboard
    logic [87:0] exp_q [$];
    logic [55:0] msk_q [$];
    int checks   = 0;
    int failures = 0;
    int rec_n    = 0;

    task automatic step(input logic r, input logic s, input logic z,
                        input logic [31:0] epc, input logic [55:0] eo, input logic [55:0] em);
        @(negedge clk);
        rst_n = r;
        stall = s;
        Zero  = z;
        exp_q.push_back({epc, eo});
        msk_q.push_back(em);
    endtask

    // monitor: one record per active edge once the driver has queued one
    always begin
        logic [87:0] e;
        logic [55:0] m;
        logic [55:0] got;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            m   = msk_q.pop_front();
            got = {valid, illegal, ImmOp, rs1, rs2, rd, RegWrite, ALUctrl, ALUsrc, MemWrite, ResultSrc};
            checks++;
            if (pc !== e[87:56]) begin
                failures++;
                $display("FAIL pc rec=%0d got=%h exp=%h", rec_n, pc, e[87:56]);
            end
            checks++;
            if ((got & m) !== (e[55:0] & m)) begin
                failures++;
                $display("FAIL outs rec=%0d got=%h exp=%h mask=%h", rec_n, got, e[55:0], m);
            end
            rec_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
        rom[0] = 32'h0050_0093;  // addi x1,x0,5
        rom[1] = 32'hFE20_AE23;  // sw   x2,-4(x1)
        rom[2] = 32'h0020_81B3;  // add  x3,x1,x2
        rom[3] = 32'h0081_2203;  // lw   x4,8(x2)
        rom[4] = 32'hFE20_9CE3;  // bne  x1,x2,-8
        rom[5] = 32'hFFF0_0293;  // addi x5,x0,-1
        rom[6] = 32'h0060_0313;  // addi x6,x0,6
        rom[7] = 32'hFFFF_FFFF;  // unsupported
        rom[8] = 32'h0070_0393;  // addi x7,x0,7
        rst_n = 1'b0;
        stall = 1'b0;
        Zero  = 1'b1;

        // reset, sequential run, bne not taken, illegal pulse
        step(0, 0, 1, 32'h00, BUB,   M_ALL);
        step(0, 0, 1, 32'h00, BUB,   M_ALL);
        step(1, 0, 1, 32'h04, BUB,   M_ALL);
        step(1, 0, 1, 32'h08, ADDI1, M_I);
        step(1, 0, 1, 32'h0C, SW,    M_ALL);
        step(1, 0, 1, 32'h10, ADD3,  M_R);
        step(1, 0, 1, 32'h14, LW4,   M_I);
        step(1, 0, 1, 32'h18, BNE,   M_ALL);
        step(1, 0, 1, 32'h1C, ADDI5, M_I);
        step(1, 0, 1, 32'h20, ADDI6, M_I);
        step(1, 0, 1, 32'h24, ILL,   M_ALL);
        step(1, 0, 1, 32'h28, ADDI7, M_I);
        step(1, 0, 1, 32'h2C, NOP,   M_I);

        // reset mid-stream, then bne taken back to 0x08 (Zero=0 on non-branches is harmless)
        step(0, 0, 0, 32'h00, BUB,   M_ALL);
        step(1, 0, 0, 32'h04, BUB,   M_ALL);
        step(1, 0, 0, 32'h08, ADDI1, M_I);
        step(1, 0, 0, 32'h0C, SW,    M_ALL);
        step(1, 0, 0, 32'h10, ADD3,  M_R);
        step(1, 0, 0, 32'h14, LW4,   M_I);
        step(1, 0, 0, 32'h18, BNE,   M_ALL);
        step(1, 0, 0, 32'h08, BUB,   M_ALL);
        step(1, 0, 0, 32'h0C, BUB,   M_ALL);
        step(1, 0, 0, 32'h10, ADD3,  M_R);
        step(1, 0, 0, 32'h14, LW4,   M_I);
        step(1, 0, 0, 32'h18, BNE,   M_ALL);
        step(1, 0, 1, 32'h1C, ADDI5, M_I);

        // three-cycle stall, then stall held over an illegal word
        step(1, 1, 1, 32'h1C, BUB,   M_ALL);
        step(1, 1, 1, 32'h1C, BUB,   M_ALL);
        step(1, 1, 1, 32'h1C, BUB,   M_ALL);
        step(1, 0, 1, 32'h20, ADDI6, M_I);
        step(1, 1, 1, 32'h20, BUB,   M_ALL);
        step(1, 1, 1, 32'h20, BUB,   M_ALL);
        step(1, 0, 1, 32'h24, ILL,   M_ALL);
        step(1, 0, 1, 32'h28, ADDI7, M_I);
        step(1, 0, 1, 32'h2C, NOP,   M_I);

        // reset, then stall and taken branch on the same edge
        step(0, 0, 1, 32'h00, BUB,   M_ALL);
        step(1, 0, 1, 32'h04, BUB,   M_ALL);
        step(1, 0, 1, 32'h08, ADDI1, M_I);
        step(1, 0, 1, 32'h0C, SW,    M_ALL);
        step(1, 0, 1, 32'h10, ADD3,  M_R);
        step(1, 0, 1, 32'h14, LW4,   M_I);
        step(1, 0, 1, 32'h18, BNE,   M_ALL);
        step(1, 1, 0, 32'h08, BUB,   M_ALL);
        step(1, 0, 1, 32'h0C, BUB,   M_ALL);
        step(1, 0, 1, 32'h10, ADD3,  M_R);
        step(1, 0, 1, 32'h14, LW4,   M_I);
        step(1, 0, 1, 32'h18, BNE,   M_ALL);
        step(1, 0, 1, 32'h1C, ADDI5, M_I);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
